cv32e41p_fetch_queue: RTL and testbench
=======================================

# cv32e41p_fetch_queue

Parametrised instruction fetch front-end for the cv32e41p IF stage. It issues OBI instruction requests with a configurable number of outstanding transactions and buffers responses in a configurable-depth FIFO. It realigns 16/32-bit instructions across word boundaries and presents one decoded-width instruction per handshake to the IF/ID register. On redirect it discards in-flight responses, so the IF stage sees only instructions from the new stream.

## Interface
Parameters:
- DEPTH, 2: fetch FIFO entries (32-bit words), legal 2..8.
- MAX_OUTSTANDING, 2: maximum granted-but-not-returned OBI transactions, legal 1..4, must be <= DEPTH.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_i  in  1  fetch enable; 0 stops new requests, outstanding ones still complete.
- branch_i  in  1  redirect strobe, single cycle.
- branch_addr_i  in  32  redirect target, bit 0 ignored (halfword-aligned).
- instr_req_o  out  1  OBI request.
- instr_addr_o  out  32  OBI word address, [1:0]=0.
- instr_gnt_i  in  1  OBI grant.
- instr_rvalid_i  in  1  OBI response valid.
- instr_rdata_i  in  32  OBI response data.
- instr_err_i  in  1  OBI bus error, qualified by instr_rvalid_i.
- out_valid_o  out  1  instruction available.
- out_ready_i  in  1  consumer accepts instruction.
- out_instr_o  out  32  instruction; compressed ones zero-extended in [31:16].
- out_pc_o  out  32  PC of out_instr_o.
- out_compressed_o  out  1  out_instr_o[1:0] != 2'b11.
- out_err_o  out  1  instruction came from an erroneous fetch.
- busy_o  out  1  outstanding != 0 or instr_req_o.

## Operation
- Counters: outstanding (0..MAX_OUTSTANDING), discard (0..MAX_OUTSTANDING), FIFO occupancy (0..DEPTH), fetch address register faddr.
- Request rule: instr_req_o = req_i & ~halted & (outstanding < MAX_OUTSTANDING) & (occupancy + outstanding - discard < DEPTH). A transaction counts when instr_req_o & instr_gnt_i; faddr += 4 on grant.
- OBI stability: once instr_req_o is high without grant, instr_addr_o and instr_req_o hold until granted, even across branch_i or req_i=0. A transaction granted after a redirect still belongs to the old stream and is added to discard.
- Response: on instr_rvalid_i, outstanding decrements. If discard>0, the response is dropped and discard decrements. Otherwise {rdata, err} is pushed to the FIFO.
- Redirect (branch_i): FIFO flushed; discard = outstanding + pending-unacked request (if any); faddr = {branch_addr_i[31:2],2'b00}; aligner pc = {branch_addr_i[31:1],1'b0}; halfword buffer cleared; halted cleared.
- Aligner: pc[1]=0 with head[1:0]!=11 outputs a 16-bit instruction and sets pc+=2, keeping the head. pc[1]=0 with a 32-bit instruction outputs the full head, pops it, and sets pc+=4. pc[1]=1 with head[17:16]!=11 outputs head[31:16], pops, and sets pc+=2. pc[1]=1 otherwise needs head and next entry, outputs {next[15:0], head[31:16]}, pops one, sets pc+=4, and keeps the next entry.
- out_valid_o = all constituent halves present. out_err_o = OR of the constituents' err. When out_err_o=1, out_instr_o=0.
- Error: a pushed word with err=1 sets halted, which blocks new requests until branch_i.
- Arithmetic: pc and faddr wrap modulo 2^32; 0xFFFF_FFFC + 4 = 0.

## Timing
- Reset values: instr_req_o=0, instr_addr_o=0, out_valid_o=0, out_instr_o=0, out_pc_o=0, out_compressed_o=0, out_err_o=0, busy_o=0, all counters 0, halted=1. The first fetch requires branch_i.
- Redirect at cycle N: out_valid_o=0 in cycle N (combinationally masked) and from N+1 until the new data arrives. The earliest instr_req_o for the new target is N+1.
- Minimum latency: grant at cycle G, rvalid at G+1, push at the G+1 edge, out_valid_o at G+2. There is no FIFO bypass.
- branch_i & out_ready_i in the same cycle: the redirect wins, with no pop and no pc advance.
- branch_i & instr_rvalid_i in the same cycle: the response is dropped.
- FIFO full: no request is issued. A full FIFO cannot overflow, because reservation counts outstanding transactions.
- rst_n asserted mid-transaction: everything returns to reset values. Late rvalids after reset deassertion are illegal (bus reset together with the core).

## Test plan
- Reset, branch_i to 0x0000_0080 with zero-wait memory of 32-bit instructions: first req at 0x80, out_pc_o sequence 0x80, 0x84, 0x88. With MAX_OUTSTANDING=2 and a stalled consumer, at most DEPTH words are buffered.
- Mixed stream at 0x100: words 0x4501_0001 (two compressed), 0x0000_0013: out_pc_o 0x100 (c, 0x0001), 0x102 (c, 0x4501), 0x104 (0x0000_0013).
- Misaligned: branch to 0x202, word0[31:16]=0x0513, word1[15:0]=0x0000: single 32-bit output 0x0000_0513 at pc 0x202.
- Redirect with 2 outstanding and a held ungranted request: all 3 old responses dropped; only new-target data appears; instr_addr_o stays stable until the grant.
- instr_err_i on the second word: second instruction has out_err_o=1, out_instr_o=0, no further req until branch_i, then normal fetch resumes.
- Wrap: branch to 0xFFFF_FFFC: the next request address is 0x0000_0000.

Source files
------------

// File: rtl/cv32e41p_fetch_queue.sv
// cv32e41p_fetch_queue
// Instruction fetch front-end: issues OBI word fetches with up to
// MAX_OUTSTANDING transactions in flight, buffers responses in a DEPTH-entry
// FIFO and realigns 16/32-bit instructions for the IF/ID register.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_i                   fetch enable (outstanding transactions still complete)
//   branch_i/branch_addr_i  single-cycle redirect and its halfword-aligned target
//   instr_req_o/addr_o      OBI request and word address
//   instr_gnt_i             OBI grant
//   instr_rvalid_i/rdata_i/err_i  OBI response
//   out_valid_o/ready_i     instruction handshake towards IF/ID
//   out_instr_o/pc_o        instruction (compressed zero-extended) and its PC
//   out_compressed_o        instruction is 16-bit
//   out_err_o               instruction came from a fetch that returned a bus error
//   busy_o                  transactions outstanding or request pending
module cv32e41p_fetch_queue #(
    parameter int unsigned DEPTH           = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_compressed_o,
    output logic        out_err_o,
    output logic        busy_o
);

    // Counter width covers occupancy + outstanding + discard sums (max 8 + 4).
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0]      faddr_q, faddr_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [PTR_W-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic             halted_q, halted_d;
    logic             hold_q, hold_d;
    logic             hold_stale_q, hold_stale_d;
    logic [31:0]      hold_addr_q, hold_addr_d;

    logic [31:0]      fifo_data_q [DEPTH];
    logic             fifo_err_q  [DEPTH];

    logic             req_ok;
    logic             xfer;
    logic             drop;
    logic             push;
    logic             fire;
    logic             pop;
    logic [PTR_W-1:0] rptr_nx;
    logic [PTR_W-1:0] wptr_nx;

    // Aligner selection
    logic [31:0]      head;
    logic             head_err;
    logic             al_avail;
    logic             al_pop;
    logic             al_err;
    logic [31:0]      al_instr;
    logic [31:0]      al_inc;

    // Only halfword alignment of the redirect target matters.
    logic             unused_addr_bit;
    assign unused_addr_bit = branch_addr_i[0];

    // Request generation: reservation counts in-flight words against FIFO space;
    // in-flight words that will be discarded do not need space.
    assign req_ok = req_i & ~halted_q
                  & (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                  & ((occ_q + outstanding_q) < (CNT_W'(DEPTH) + discard_q));

    // A held (ungranted) request keeps request and address stable until granted.
    assign instr_req_o  = hold_q | req_ok;
    assign instr_addr_o = hold_q ? hold_addr_q : faddr_q;
    assign xfer         = instr_req_o & instr_gnt_i;
    assign busy_o       = (outstanding_q != '0) | instr_req_o;

    // Response routing: drop while discarding or when redirected this cycle.
    assign drop = branch_i | (discard_q != '0);
    assign push = instr_rvalid_i & ~drop;

    assign rptr_nx = (rptr_q == PTR_W'(DEPTH - 1)) ? '0 : rptr_q + PTR_W'(1);
    assign wptr_nx = (wptr_q == PTR_W'(DEPTH - 1)) ? '0 : wptr_q + PTR_W'(1);

    assign head     = fifo_data_q[rptr_q];
    assign head_err = fifo_err_q[rptr_q];

    // Aligner: picks the instruction at pc from the head (and next) FIFO words.
    always_comb begin
        al_avail = 1'b0;
        al_pop   = 1'b0;
        al_err   = 1'b0;
        al_instr = '0;
        al_inc   = 32'd2;
        if (!pc_q[1]) begin
            al_avail = (occ_q != '0);
            al_err   = head_err;
            if (head[1:0] != 2'b11) begin
                al_instr = {16'h0000, head[15:0]};
            end else begin
                al_instr = head;
                al_pop   = 1'b1;
                al_inc   = 32'd4;
            end
        end else if (head[17:16] != 2'b11) begin
            al_avail = (occ_q != '0);
            al_err   = head_err;
            al_instr = {16'h0000, head[31:16]};
            al_pop   = 1'b1;
        end else begin
            // 32-bit instruction straddling two words
            al_avail = (occ_q >= CNT_W'(2));
            al_err   = head_err | fifo_err_q[rptr_nx];
            al_instr = {fifo_data_q[rptr_nx][15:0], head[31:16]};
            al_pop   = 1'b1;
            al_inc   = 32'd4;
        end
    end

    // Redirect masks the output in the same cycle.
    assign out_valid_o      = al_avail & ~branch_i;
    assign out_err_o        = out_valid_o & al_err;
    assign out_instr_o      = (out_valid_o & ~al_err) ? al_instr : 32'h0;
    assign out_compressed_o = out_valid_o & (out_instr_o[1:0] != 2'b11);
    assign out_pc_o         = pc_q;

    assign fire = out_valid_o & out_ready_i;
    assign pop  = fire & al_pop;

    // Next-state computation for counters, pointers and address registers.
    always_comb begin
        faddr_d       = faddr_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q + CNT_W'(xfer) - CNT_W'(instr_rvalid_i);
        discard_d     = discard_q;
        occ_d         = occ_q;
        rptr_d        = rptr_q;
        wptr_d        = wptr_q;
        halted_d      = halted_q;
        hold_d        = 1'b0;
        hold_stale_d  = 1'b0;
        hold_addr_d   = hold_addr_q;

        // Request held without grant; remember whether it predates a redirect.
        if (instr_req_o && !instr_gnt_i) begin
            hold_d       = 1'b1;
            hold_addr_d  = instr_addr_o;
            hold_stale_d = hold_stale_q | branch_i;
        end

        if (branch_i) begin
            // Everything still to come back, including a pending request, is old.
            discard_d = outstanding_q + CNT_W'(instr_req_o) - CNT_W'(instr_rvalid_i);
            faddr_d   = {branch_addr_i[31:2], 2'b00};
            pc_d      = {branch_addr_i[31:1], 1'b0};
            occ_d     = '0;
            rptr_d    = '0;
            wptr_d    = '0;
            halted_d  = 1'b0;
        end else begin
            if (instr_rvalid_i && discard_q != '0) begin
                discard_d = discard_q - CNT_W'(1);
            end
            // A stale held request granted now must not advance the new stream.
            if (xfer && !(hold_q && hold_stale_q)) begin
                faddr_d = faddr_q + 32'd4;
            end
            if (push) begin
                wptr_d = wptr_nx;
                if (instr_err_i) begin
                    halted_d = 1'b1;
                end
            end
            if (pop) begin
                rptr_d = rptr_nx;
            end
            if (fire) begin
                pc_d = pc_q + al_inc;
            end
            occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            faddr_q       <= '0;
            pc_q          <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            occ_q         <= '0;
            rptr_q        <= '0;
            wptr_q        <= '0;
            halted_q      <= 1'b1;
            hold_q        <= 1'b0;
            hold_stale_q  <= 1'b0;
            hold_addr_q   <= '0;
        end else begin
            faddr_q       <= faddr_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            occ_q         <= occ_d;
            rptr_q        <= rptr_d;
            wptr_q        <= wptr_d;
            halted_q      <= halted_d;
            hold_q        <= hold_d;
            hold_stale_q  <= hold_stale_d;
            hold_addr_q   <= hold_addr_d;
        end
    end

    // FIFO storage; contents are qualified by occupancy so need no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wptr_q] <= instr_rdata_i;
            fifo_err_q[wptr_q]  <= instr_err_i;
        end
    end

endmodule

// File: tb/tb_cv32e41p_fetch_queue.sv
// Directed bench for cv32e41p_fetch_queue with a simple OBI memory model.
module tb_cv32e41p_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_err_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_compressed_o;
    logic        out_err_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    // memory model controls and logs
    logic        gnt_en = 1'b1;
    logic        rsp_en = 1'b1;
    logic        err_en = 1'b0;
    logic [31:0] err_addr = 32'h0;
    logic [31:0] pq[$];
    logic [31:0] glog[$];

    cv32e41p_fetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_i            (req_i),
        .branch_i         (branch_i),
        .branch_addr_i    (branch_addr_i),
        .instr_req_o      (instr_req_o),
        .instr_addr_o     (instr_addr_o),
        .instr_gnt_i      (instr_gnt_i),
        .instr_rvalid_i   (instr_rvalid_i),
        .instr_rdata_i    (instr_rdata_i),
        .instr_err_i      (instr_err_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_instr_o      (out_instr_o),
        .out_pc_o         (out_pc_o),
        .out_compressed_o (out_compressed_o),
        .out_err_o        (out_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0100: mem_word = 32'h4501_0001;
            32'h0000_0104: mem_word = 32'h0000_0013;
            32'h0000_0200: mem_word = 32'h0513_4501;
            32'h0000_0204: mem_word = 32'h1234_0000;
            default:       mem_word = {a[23:0], 8'h13};
        endcase
    endfunction

    function automatic logic [31:0] glog_at(input int i);
        glog_at = (glog.size() > i) ? glog[i] : 32'hDEAD_BEEF;
    endfunction

    // OBI memory: responses one or more cycles after grant, in order.
    initial begin
        instr_gnt_i    = 1'b0;
        instr_rvalid_i = 1'b0;
        instr_rdata_i  = 32'h0;
        instr_err_i    = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_en && pq.size() > 0) begin
                logic [31:0] a;
                a = pq.pop_front();
                instr_rvalid_i = 1'b1;
                instr_rdata_i  = mem_word(a);
                instr_err_i    = err_en && (a == err_addr);
            end else begin
                instr_rvalid_i = 1'b0;
                instr_rdata_i  = 32'h0;
                instr_err_i    = 1'b0;
            end
            if (gnt_en && instr_req_o) begin
                instr_gnt_i = 1'b1;
                pq.push_back(instr_addr_o);
                glog.push_back(instr_addr_o);
            end else begin
                instr_gnt_i = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_branch(input logic [31:0] addr, input bit chk_mask, input bit rdy);
        step();
        branch_i      = 1'b1;
        branch_addr_i = addr;
        out_ready_i   = rdy;
        #1;
        if (chk_mask) check_eq("branch_mask", 32'(out_valid_o), 32'h0);
        step();
        branch_i    = 1'b0;
        out_ready_i = 1'b0;
        #1;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                             input bit comp, input bit err, input bit chk_comp);
        for (int i = 0; i < 40; i++) begin
            if (out_valid_o) break;
            step();
        end
        check_eq({tag, "_valid"}, 32'(out_valid_o), 32'h1);
        if (out_valid_o) begin
            check_eq({tag, "_pc"}, out_pc_o, pc);
            check_eq({tag, "_instr"}, out_instr_o, ins);
            check_eq({tag, "_err"}, 32'(out_err_o), 32'(err));
            if (chk_comp) check_eq({tag, "_comp"}, 32'(out_compressed_o), 32'(comp));
            out_ready_i = 1'b1;
            step();
            out_ready_i = 1'b0;
            #1;
        end
    endtask

    task automatic quiesce();
        out_ready_i = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (!busy_o) break;
            step();
        end
        check_eq("quiesce_busy", 32'(busy_o), 32'h0);
    endtask

    task automatic wait_grants(input int n, input int bound);
        for (int i = 0; i < bound; i++) begin
            if (glog.size() >= n) break;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rst_n         = 1'b0;
        req_i         = 1'b1;
        branch_i      = 1'b0;
        branch_addr_i = 32'h0;
        out_ready_i   = 1'b0;
        repeat (3) step();
        check_eq("rst_req", 32'(instr_req_o), 32'h0);
        check_eq("rst_addr", instr_addr_o, 32'h0);
        check_eq("rst_valid", 32'(out_valid_o), 32'h0);
        check_eq("rst_instr", out_instr_o, 32'h0);
        check_eq("rst_pc", out_pc_o, 32'h0);
        check_eq("rst_comp", 32'(out_compressed_o), 32'h0);
        check_eq("rst_err", 32'(out_err_o), 32'h0);
        check_eq("rst_busy", 32'(busy_o), 32'h0);
        rst_n = 1'b1;
        step();
        check_eq("halted_after_reset", 32'(instr_req_o), 32'h0);

        // 32-bit stream at 0x80, consumer stalled until FIFO fills
        glog.delete();
        do_branch(32'h0000_0080, 1'b0, 1'b0);
        check_eq("t1_first_req", 32'(instr_req_o), 32'h1);
        check_eq("t1_first_addr", instr_addr_o, 32'h0000_0080);
        repeat (20) step();
        check_eq("t1_grants_eq_depth", 32'(glog.size()), 32'(DEPTH));
        check_eq("t1_full_no_req", 32'(instr_req_o), 32'h0);
        check_eq("t1_full_idle", 32'(busy_o), 32'h0);
        pop_check("t1_i0", 32'h0000_0080, 32'h0000_8013, 1'b0, 1'b0, 1'b1);
        pop_check("t1_i1", 32'h0000_0084, 32'h0000_8413, 1'b0, 1'b0, 1'b1);
        pop_check("t1_i2", 32'h0000_0088, 32'h0000_8813, 1'b0, 1'b0, 1'b1);

        // mixed compressed stream; redirect with out_ready_i high wins
        do_branch(32'h0000_0100, 1'b1, 1'b1);
        pop_check("t2_c0", 32'h0000_0100, 32'h0000_0001, 1'b1, 1'b0, 1'b1);
        pop_check("t2_c1", 32'h0000_0102, 32'h0000_4501, 1'b1, 1'b0, 1'b1);
        pop_check("t2_w", 32'h0000_0104, 32'h0000_0013, 1'b0, 1'b0, 1'b1);

        // misaligned 32-bit instruction spanning two words
        do_branch(32'h0000_0202, 1'b0, 1'b0);
        pop_check("t3_span", 32'h0000_0202, 32'h0000_0513, 1'b0, 1'b0, 1'b1);

        // redirect with two outstanding and one held request
        quiesce();
        rsp_en = 1'b0;
        gnt_en = 1'b1;
        glog.delete();
        do_branch(32'h0000_0300, 1'b0, 1'b0);
        wait_grants(2, 10);
        gnt_en = 1'b0;
        step();
        check_eq("t4_two_grants", 32'(glog.size()), 32'h2);
        check_eq("t4_held_req", 32'(instr_req_o), 32'h1);
        check_eq("t4_held_addr", instr_addr_o, 32'h0000_0308);
        do_branch(32'h0000_0400, 1'b1, 1'b0);
        check_eq("t4_req_stable", 32'(instr_req_o), 32'h1);
        check_eq("t4_addr_stable", instr_addr_o, 32'h0000_0308);
        gnt_en = 1'b1;
        rsp_en = 1'b1;
        wait_grants(4, 20);
        check_eq("t4_stale_grant", glog_at(2), 32'h0000_0308);
        check_eq("t4_new_grant", glog_at(3), 32'h0000_0400);
        pop_check("t4_new0", 32'h0000_0400, 32'h0004_0013, 1'b0, 1'b0, 1'b1);
        pop_check("t4_new1", 32'h0000_0404, 32'h0004_0413, 1'b0, 1'b0, 1'b1);

        // bus error on the second word halts fetching until redirect
        quiesce();
        err_en   = 1'b1;
        err_addr = 32'h0000_0504;
        do_branch(32'h0000_0500, 1'b0, 1'b0);
        pop_check("t5_ok", 32'h0000_0500, 32'h0005_0013, 1'b0, 1'b0, 1'b1);
        pop_check("t5_errw", 32'h0000_0504, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        out_ready_i = 1'b1;
        repeat (15) step();
        snap = glog.size();
        repeat (10) step();
        check_eq("t5_no_new_grants", 32'(glog.size()), 32'(snap));
        check_eq("t5_halt_no_req", 32'(instr_req_o), 32'h0);
        check_eq("t5_halt_idle", 32'(busy_o), 32'h0);
        out_ready_i = 1'b0;
        err_en = 1'b0;
        do_branch(32'h0000_0600, 1'b0, 1'b0);
        pop_check("t5_resume", 32'h0000_0600, 32'h0006_0013, 1'b0, 1'b0, 1'b1);

        // address wrap at the top of the address space
        quiesce();
        glog.delete();
        do_branch(32'hFFFF_FFFC, 1'b0, 1'b0);
        wait_grants(2, 10);
        check_eq("t6_top_addr", glog_at(0), 32'hFFFF_FFFC);
        check_eq("t6_wrap_addr", glog_at(1), 32'h0000_0000);
        pop_check("t6_top", 32'hFFFF_FFFC, 32'hFFFF_FC13, 1'b0, 1'b0, 1'b1);
        pop_check("t6_zero", 32'h0000_0000, 32'h0000_0013, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
